// File: rtl/seven_seg_scan_ctrl_if.sv
`default_nettype none
// ============================================================================
//  Module   : seven_seg_scan_ctrl_if
//  Brief    : Load port and decoder-side signals of the seven-segment scan
//             controller. The master side offers display data and observes
//             the scan outputs. The slave side is the controller itself.
//  Revision : 1.0 - initial release
// ============================================================================
interface seven_seg_scan_ctrl_if;
  logic        load_valid;
  logic        load_ready;
  logic [31:0] value;
  logic [7:0]  dp_mask;
  logic [7:0]  digit_en;
  logic        lz_en;
  logic [3:0]  seg_nibble;
  logic [7:0]  an_sel;
  logic        dp_out;
  logic        frame_done;

  modport master (
    output load_valid, value, dp_mask, digit_en, lz_en,
    input  load_ready, seg_nibble, an_sel, dp_out, frame_done
  );

  modport slave (
    input  load_valid, value, dp_mask, digit_en, lz_en,
    output load_ready, seg_nibble, an_sel, dp_out, frame_done
  );
endinterface
`default_nettype wire

// File: rtl/seven_seg_scan_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : seven_seg_scan_ctrl
//  Brief    : Time-multiplexed scan of an 8-digit seven-segment display.
//             Each digit slot opens with a short all-dark gap (anti-ghosting)
//             and is followed by the on-time. New data is double-buffered and
//             committed only at frame boundaries, so a frame never tears.
//  Revision : 1.0 - initial release
// ============================================================================
module seven_seg_scan_ctrl #(
  parameter int TICK_DIV  = 100000,  // cycles per digit slot (gap + on-time)
  parameter int GHOST_GAP = 16       // dark cycles at the start of each slot
) (
  input  logic                  clk,
  input  logic                  rst,
  seven_seg_scan_ctrl_if.slave  bus
);

  localparam int c_CNT_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [c_CNT_W-1:0] c_SLOT_LAST = c_CNT_W'(TICK_DIV - 1);
  localparam logic [c_CNT_W-1:0] c_GAP_LAST  = c_CNT_W'(GHOST_GAP - 1);

  localparam logic [0:0] c_ST_GAP = 1'b0;
  localparam logic [0:0] c_ST_ON  = 1'b1;

  // Scan position
  logic [0:0]         r_state;
  logic [c_CNT_W-1:0] r_cnt;
  logic [2:0]         r_idx;

  // Active (displayed) and pending (waiting for the frame boundary) buffers
  logic [31:0] r_act_value;
  logic [7:0]  r_act_dp;
  logic [7:0]  r_act_en;
  logic [31:0] r_pend_value;
  logic [7:0]  r_pend_dp;
  logic [7:0]  r_pend_en;
  logic        r_pend;

  // Registered decoder outputs
  logic [3:0]  r_seg_nibble;
  logic [7:0]  r_an_sel;
  logic        r_dp_out;
  logic        r_frame_done;

  logic        w_slot_end;
  logic        w_frame_end;
  logic        w_accept;
  logic [3:0]  w_nib;
  logic        w_dp_bit;
  logic        w_en_bit;
  logic        w_suppress;
  logic [7:0]  w_onehot;
  logic [3:0]  w_next_nibble;
  logic [7:0]  w_next_an;
  logic        w_next_dp;

  assign w_slot_end  = (r_cnt == c_SLOT_LAST);
  assign w_frame_end = w_slot_end && (r_idx == 3'd7);
  // A full pending buffer holds off the source until the next commit.
  assign w_accept    = bus.load_valid && !r_pend;

  assign w_nib    = r_act_value[{r_idx, 2'b00} +: 4];
  assign w_dp_bit = r_act_dp[r_idx];
  assign w_en_bit = r_act_en[r_idx];
  assign w_onehot = 8'b1 << r_idx;
  // Digit is blanked as a leading zero when it and every digit above it is zero.
  assign w_suppress = bus.lz_en && (r_idx != 3'd0) &&
                      ((r_act_value >> {r_idx, 2'b00}) == 32'h0);

  // Decide what the decoder sees for the current scan position
  always_comb begin
    w_next_nibble = w_nib;
    w_next_an     = 8'h00;
    w_next_dp     = 1'b0;
    if (r_state == c_ST_ON) begin
      w_next_dp = w_dp_bit;
      if (w_suppress) begin
        // A blanked digit stays lit only to show its decimal point.
        if (w_dp_bit) begin
          w_next_nibble = 4'hF;
          if (w_en_bit) begin
            w_next_an = w_onehot;
          end
        end
      end else if (w_en_bit) begin
        w_next_an = w_onehot;
      end
    end
  end

  // Slot counter, gap/on state and digit index
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= c_ST_GAP;
      r_cnt   <= '0;
      r_idx   <= 3'd0;
    end else begin
      r_cnt <= w_slot_end ? '0 : r_cnt + 1'b1;
      case (r_state)
        c_ST_GAP: begin
          if (r_cnt == c_GAP_LAST) begin
            r_state <= c_ST_ON;
          end
        end
        c_ST_ON: begin
          if (w_slot_end) begin
            r_state <= c_ST_GAP;
            r_idx   <= r_idx + 3'd1;
          end
        end
        default: r_state <= c_ST_GAP;
      endcase
    end
  end

  // Load capture into the pending buffer and commit at the frame boundary
  always_ff @(posedge clk) begin
    if (rst) begin
      r_pend       <= 1'b0;
      r_pend_value <= 32'h0;
      r_pend_dp    <= 8'h00;
      r_pend_en    <= 8'h00;
      r_act_value  <= 32'h0;
      r_act_dp     <= 8'h00;
      r_act_en     <= 8'h00;
    end else begin
      if (w_frame_end && r_pend) begin
        r_act_value <= r_pend_value;
        r_act_dp    <= r_pend_dp;
        r_act_en    <= r_pend_en;
        r_pend      <= 1'b0;
      end
      // Acceptance needs an empty buffer, so it can never collide with a
      // commit; data taken on a boundary edge waits for the next boundary.
      if (w_accept) begin
        r_pend_value <= bus.value;
        r_pend_dp    <= bus.dp_mask;
        r_pend_en    <= bus.digit_en;
        r_pend       <= 1'b1;
      end
    end
  end

  // Register the decoder outputs one cycle behind the scan state
  always_ff @(posedge clk) begin
    if (rst) begin
      r_seg_nibble <= 4'h0;
      r_an_sel     <= 8'h00;
      r_dp_out     <= 1'b0;
      r_frame_done <= 1'b0;
    end else begin
      r_seg_nibble <= w_next_nibble;
      r_an_sel     <= w_next_an;
      r_dp_out     <= w_next_dp;
      r_frame_done <= w_frame_end;
    end
  end

  assign bus.seg_nibble = r_seg_nibble;
  assign bus.an_sel     = r_an_sel;
  assign bus.dp_out     = r_dp_out;
  assign bus.frame_done = r_frame_done;
  assign bus.load_ready = !r_pend;

endmodule
`default_nettype wire

// File: tb/tb_seven_seg_scan_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : tb_seven_seg_scan_ctrl
//  Brief    : Self-checking bench for the seven-segment scan controller.
//             A reference model derives the expected outputs from the cycle
//             count since reset and a simple pending/active data model.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_seven_seg_scan_ctrl;
  localparam int TICK_DIV  = 8;
  localparam int GHOST_GAP = 2;
  localparam int FRAME     = 8 * TICK_DIV;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  seven_seg_scan_ctrl_if bus_if ();

  seven_seg_scan_ctrl #(
    .TICK_DIV (TICK_DIV),
    .GHOST_GAP(GHOST_GAP)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus_if)
  );

  // Reference model state
  int unsigned k;
  bit          m_pend;
  logic [31:0] m_act_val, m_pen_val;
  logic [7:0]  m_act_dp, m_act_en, m_pen_dp, m_pen_en;
  logic [3:0]  e_nib;
  logic [7:0]  e_an;
  logic        e_dp, e_fd, e_rdy;
  bit          accepted_now, committed_now;

  int tests = 0;
  int fails = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    assert (got === exp) else begin
      fails++;
      $error("FAIL %s at k=%0d: got %h, expected %h", tag, k, got, exp);
    end
  endtask

  // Advance the model across one rising edge using the inputs seen at that edge.
  task automatic model_edge();
    int pos, idx;
    bit supp, dpb, enb;
    accepted_now  = 0;
    committed_now = 0;
    if (rst) begin
      k = 0; m_pend = 0;
      m_act_val = 0; m_act_dp = 0; m_act_en = 0;
      m_pen_val = 0; m_pen_dp = 0; m_pen_en = 0;
      e_nib = 0; e_an = 0; e_dp = 0; e_fd = 0; e_rdy = 1;
      return;
    end
    pos   = k % TICK_DIV;
    idx   = (k / TICK_DIV) % 8;
    dpb   = m_act_dp[idx];
    enb   = m_act_en[idx];
    e_nib = 4'((m_act_val >> (4 * idx)) & 32'hF);
    e_an  = 8'h00;
    e_dp  = 1'b0;
    if (pos >= GHOST_GAP) begin
      e_dp = dpb;
      supp = bus_if.lz_en && (idx > 0) && ((m_act_val >> (4 * idx)) == 32'h0);
      if (!supp) begin
        if (enb) e_an = 8'(1 << idx);
      end else if (dpb) begin
        e_nib = 4'hF;
        if (enb) e_an = 8'(1 << idx);
      end
    end
    if (((k + 1) % FRAME) == 0 && m_pend) begin
      m_act_val = m_pen_val; m_act_dp = m_pen_dp; m_act_en = m_pen_en;
      m_pend = 0;
      committed_now = 1;
    end else if (bus_if.load_valid && !m_pend) begin
      m_pen_val = bus_if.value; m_pen_dp = bus_if.dp_mask; m_pen_en = bus_if.digit_en;
      m_pend = 1;
      accepted_now = 1;
    end
    k++;
    e_fd  = ((k % FRAME) == 0);
    e_rdy = !m_pend;
  endtask

  task automatic cycle();
    @(posedge clk);
    model_edge();
    @(negedge clk);
    chk("seg_nibble", 32'(bus_if.seg_nibble), 32'(e_nib));
    chk("an_sel",     32'(bus_if.an_sel),     32'(e_an));
    chk("dp_out",     32'(bus_if.dp_out),     32'(e_dp));
    chk("frame_done", 32'(bus_if.frame_done), 32'(e_fd));
    chk("load_ready", 32'(bus_if.load_ready), 32'(e_rdy));
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) cycle();
  endtask

  // Offer data and hold it until taken; garble the inputs afterwards.
  task automatic load(input logic [31:0] v, input logic [7:0] dp, input logic [7:0] en);
    bit ok = 0;
    bus_if.value = v; bus_if.dp_mask = dp; bus_if.digit_en = en;
    bus_if.load_valid = 1'b1;
    for (int i = 0; i < 2 * FRAME + 4 && !ok; i++) begin
      cycle();
      ok = accepted_now;
    end
    bus_if.load_valid = 1'b0;
    bus_if.value = $urandom; bus_if.dp_mask = 8'($urandom); bus_if.digit_en = 8'($urandom);
    chk("load_accept_timeout", 32'(ok), 32'd1);
  endtask

  task automatic wait_commit();
    bit ok = 0;
    for (int i = 0; i < FRAME + 2 && !ok; i++) begin
      cycle();
      ok = committed_now;
    end
    chk("commit_timeout", 32'(ok), 32'd1);
  endtask

  // Run until the model sits at the given phase within the frame.
  task automatic align(input int ph);
    for (int i = 0; i < FRAME && (k % FRAME) != ph; i++) cycle();
  endtask

  initial begin
    bus_if.load_valid = 0; bus_if.value = 0; bus_if.dp_mask = 0;
    bus_if.digit_en = 0; bus_if.lz_en = 0;
    k = 0;

    // Reset then idle
    rst = 1'b1;
    repeat (3) cycle();
    rst = 1'b0;
    run(2 * FRAME + 4);

    // Basic scan
    load(32'h89ABCDEF, 8'h01, 8'hFF);
    wait_commit();
    run(2 * FRAME);

    // Tear-free update: second load in digit 3 of a displayed frame
    load(32'h11111111, 8'h00, 8'hFF);
    wait_commit();
    align(3 * TICK_DIV + GHOST_GAP);
    load(32'h22222222, 8'h00, 8'hFF);
    run(2 * FRAME);

    // Accept on the boundary edge
    align(FRAME - 1);
    load(32'h33333333, 8'hF0, 8'hFF);
    run(2 * FRAME + 2);

    // Leading-zero suppression
    bus_if.lz_en = 1'b1;
    load(32'h00000A05, 8'h08, 8'hFF);
    wait_commit();
    run(FRAME + 2);
    load(32'h00000000, 8'h00, 8'hFF);
    wait_commit();
    run(FRAME + 2);
    bus_if.lz_en = 1'b0;

    // Reset mid-frame with a load pending
    load(32'h12345678, 8'hFF, 8'hFF);
    wait_commit();
    load(32'h87654321, 8'h00, 8'hFF);
    align(5 * TICK_DIV + GHOST_GAP + 1);
    rst = 1'b1;
    cycle();
    rst = 1'b0;
    run(FRAME + 4);

    // Randomized loads, enables, dp masks and live lz_en changes
    for (int i = 0; i < 1500; i++) begin
      if (!bus_if.load_valid && $urandom_range(0, 19) == 0) begin
        logic [31:0] tmp;
        tmp = $urandom;
        bus_if.value      = tmp >> (4 * $urandom_range(0, 8));
        bus_if.dp_mask    = 8'($urandom);
        bus_if.digit_en   = 8'($urandom);
        bus_if.load_valid = 1'b1;
      end
      if ($urandom_range(0, 31) == 0) bus_if.lz_en = ~bus_if.lz_en;
      cycle();
      if (accepted_now) begin
        bus_if.load_valid = 1'b0;
        bus_if.value = $urandom;
      end
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
`default_nettype wire
